// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: match phase enum, serve direction / winner encodings and
// default match tuning constants.
package pong_pkg;

  // Match phases.
  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    POINT,
    OVER
  } state_t;

  // serve_dir encodings: the ball is released toward the player who conceded.
  localparam logic DIR_TO_P2 = 1'b0;  // rightward
  localparam logic DIR_TO_P1 = 1'b1;  // leftward

  // winner encodings.
  localparam logic WIN_P1 = 1'b0;
  localparam logic WIN_P2 = 1'b1;

  // Default match tuning.
  localparam int DEF_WIN_SCORE    = 7;
  localparam int DEF_SCORE_W      = 4;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_POINT_FRAMES = 30;
  localparam int DEF_TMR_W        = 8;

endpackage

// File: rtl/frame_timer.sv
// Frame counter: counts frame ticks from zero and flags the tick that reaches load.
// Latency: done is combinational on the qualifying tick; count updates next edge.
// Backpressure: none; every tick presented is counted unless clear is high.
//
// Ports: clk_100MHz/reset (sync, active-high); clear zeroes the count;
// tick advances it; load is the target count; done marks the tick that
// brings the count up to load.
module frame_timer #(
  parameter int TMR_W = 8
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic [TMR_W-1:0] load,
  output logic             done
);

  logic [TMR_W-1:0] count;
  logic [TMR_W:0]   count_inc;

  // One extra bit so count+1 cannot alias back onto a small load value.
  assign count_inc = {1'b0, count} + {{TMR_W{1'b0}}, 1'b1};
  assign done      = tick && (count_inc == {1'b0, load});

  always_ff @(posedge clk_100MHz) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count_inc[TMR_W-1:0];
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/rally/point/game-over phases, scores and ball controls.
// Latency: one cycle from any input event (serve edge, miss, final frame tick) to outputs.
// Backpressure: none; misses outside PLAY and serve presses outside IDLE/OVER are dropped.
//
// Ports: clk_100MHz, reset (sync, active-high); frame_tick (per-frame pulse);
// serve_btn (debounced level); miss_left/miss_right (miss pulses from the ball);
// ball_hold, ball_run, serve_dir (ball controls); score1, score2; point_strobe;
// game_over, winner.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int TMR_W        = DEF_TMR_W
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               serve_btn,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_hold,
  output logic               ball_run,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               point_strobe,
  output logic               game_over,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE_S   = SCORE_W'(1);
  localparam logic [TMR_W-1:0]   SERVE_T = TMR_W'(SERVE_FRAMES);
  localparam logic [TMR_W-1:0]   POINT_T = TMR_W'(POINT_FRAMES);

  state_t             state, state_n;
  logic               btn_prev;
  logic               serve_press;
  logic               timed_phase;
  logic               tmr_clr, tmr_tick, tmr_done;
  logic [TMR_W-1:0]   tmr_load;
  logic               serve_dir_n, winner_n, point_strobe_n;
  logic [SCORE_W-1:0] score1_n, score2_n;
  logic [SCORE_W-1:0] scorer_score;

  assign serve_press = serve_btn && !btn_prev;

  // The timer only runs in SERVE and POINT and is held at zero otherwise, so
  // ticks coincident with a serve edge or a miss never count. Those phases
  // are only left through done, so clearing on done restarts the next phase.
  assign timed_phase = (state == SERVE) || (state == POINT);
  assign tmr_tick    = frame_tick && timed_phase;
  assign tmr_clr     = !timed_phase || tmr_done;
  assign tmr_load    = (state == SERVE) ? SERVE_T : POINT_T;

  // serve_dir points at the player who conceded, so it also names the scorer.
  assign scorer_score = (serve_dir == DIR_TO_P1) ? score2 : score1;

  frame_timer #(
    .TMR_W(TMR_W)
  ) u_frame_timer (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .clear     (tmr_clr),
    .tick      (tmr_tick),
    .load      (tmr_load),
    .done      (tmr_done)
  );

  always_comb begin
    state_n        = state;
    serve_dir_n    = serve_dir;
    score1_n       = score1;
    score2_n       = score2;
    winner_n       = winner;
    point_strobe_n = 1'b0;
    case (state)
      IDLE: begin
        if (serve_press) state_n = SERVE;
      end
      SERVE: begin
        if (tmr_done) state_n = PLAY;
      end
      PLAY: begin
        if (miss_left && miss_right) begin
          // Simultaneous misses: replay the serve without awarding a point.
          state_n = SERVE;
        end else if (miss_left) begin
          if (score2 != WIN_S) score2_n = score2 + ONE_S;
          serve_dir_n    = DIR_TO_P1;
          point_strobe_n = 1'b1;
          state_n        = POINT;
        end else if (miss_right) begin
          if (score1 != WIN_S) score1_n = score1 + ONE_S;
          serve_dir_n    = DIR_TO_P2;
          point_strobe_n = 1'b1;
          state_n        = POINT;
        end
      end
      POINT: begin
        if (tmr_done) begin
          if (scorer_score == WIN_S) begin
            state_n  = OVER;
            winner_n = (serve_dir == DIR_TO_P1) ? WIN_P2 : WIN_P1;
          end else begin
            state_n = SERVE;
          end
        end
      end
      OVER: begin
        if (serve_press) begin
          score1_n    = '0;
          score2_n    = '0;
          serve_dir_n = DIR_TO_P2;
          state_n     = SERVE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state        <= IDLE;
      btn_prev     <= 1'b1;
      ball_hold    <= 1'b1;
      ball_run     <= 1'b0;
      serve_dir    <= DIR_TO_P2;
      score1       <= '0;
      score2       <= '0;
      point_strobe <= 1'b0;
      game_over    <= 1'b0;
      winner       <= WIN_P1;
    end else begin
      state        <= state_n;
      btn_prev     <= serve_btn;
      ball_hold    <= (state_n != PLAY);
      ball_run     <= (state_n == PLAY);
      serve_dir    <= serve_dir_n;
      score1       <= score1_n;
      score2       <= score2_n;
      point_strobe <= point_strobe_n;
      game_over    <= (state_n == OVER);
      winner       <= winner_n;
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
module tb_pong_match_ctrl;

  localparam int M_WIN   = 3;
  localparam int M_SERVE = 60;
  localparam int M_POINT = 30;

  // Bench-side phase names for the reference model.
  localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_POINT = 3, P_OVER = 4;

  // Directed operation codes.
  localparam int OP_RSTHOLD = 0, OP_IDLE = 1, OP_PRESS = 2, OP_TICKS = 3;
  localparam int OP_ML = 4, OP_MR = 5, OP_MB = 6, OP_RST = 7;

  typedef struct {
    int op;
    int arg;
    int hold;
    int run;
    int s1;
    int s2;
    int over;
    int dir;
    int strobe;
    int win;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       serve_btn = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       ball_hold, ball_run, serve_dir, point_strobe, game_over, winner;
  logic [3:0] score1, score2;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_phase, m_frames, m_s1, m_s2, m_dir, m_win, m_strobe, m_prev;

  vec_t tbl[$];

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .WIN_SCORE   (M_WIN),
    .SCORE_W     (4),
    .SERVE_FRAMES(M_SERVE),
    .POINT_FRAMES(M_POINT),
    .TMR_W       (8)
  ) dut (
    .clk_100MHz  (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .serve_btn   (serve_btn),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .ball_hold   (ball_hold),
    .ball_run    (ball_run),
    .serve_dir   (serve_dir),
    .score1      (score1),
    .score2      (score2),
    .point_strobe(point_strobe),
    .game_over   (game_over),
    .winner      (winner)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Match rules applied to one clock's worth of inputs.
  task automatic model_step(input bit r, input bit sb, input bit ml, input bit mr, input bit ft);
    bit press;
    if (r) begin
      m_phase = P_IDLE; m_frames = 0; m_s1 = 0; m_s2 = 0;
      m_dir = 0; m_win = 0; m_strobe = 0; m_prev = 1;
    end else begin
      press    = sb && (m_prev == 0);
      m_prev   = sb;
      m_strobe = 0;
      case (m_phase)
        P_IDLE: if (press) begin m_phase = P_SERVE; m_frames = 0; end
        P_SERVE: if (ft) begin
          m_frames++;
          if (m_frames == M_SERVE) m_phase = P_PLAY;
        end
        P_PLAY: begin
          if (ml && mr) begin
            m_phase = P_SERVE; m_frames = 0;
          end else if (ml) begin
            m_s2++; m_dir = 1; m_strobe = 1; m_phase = P_POINT; m_frames = 0;
          end else if (mr) begin
            m_s1++; m_dir = 0; m_strobe = 1; m_phase = P_POINT; m_frames = 0;
          end
        end
        P_POINT: if (ft) begin
          m_frames++;
          if (m_frames == M_POINT) begin
            if (((m_dir == 1) ? m_s2 : m_s1) == M_WIN) begin
              m_phase = P_OVER; m_win = m_dir;
            end else begin
              m_phase = P_SERVE; m_frames = 0;
            end
          end
        end
        default: if (press) begin
          m_s1 = 0; m_s2 = 0; m_dir = 0; m_phase = P_SERVE; m_frames = 0;
        end
      endcase
    end
  endtask

  task automatic check_model();
    chk("m_hold",   ball_hold,    (m_phase != P_PLAY) ? 1 : 0);
    chk("m_run",    ball_run,     (m_phase == P_PLAY) ? 1 : 0);
    chk("m_over",   game_over,    (m_phase == P_OVER) ? 1 : 0);
    chk("m_s1",     score1,       m_s1);
    chk("m_s2",     score2,       m_s2);
    chk("m_dir",    serve_dir,    m_dir);
    chk("m_strobe", point_strobe, m_strobe);
    if (m_phase == P_OVER) chk("m_winner", winner, m_win);
  endtask

  // One clock: drive inputs, step the model at the edge, sample #1 later.
  task automatic cyc(input bit r, input bit sb, input bit ml, input bit mr, input bit ft);
    reset = r; serve_btn = sb; miss_left = ml; miss_right = mr; frame_tick = ft;
    @(posedge clk);
    model_step(r, sb, ml, mr, ft);
    #1;
    check_model();
  endtask

  task automatic apply_op(input int op, input int arg);
    case (op)
      OP_RSTHOLD: begin
        repeat (2) cyc(1, 1, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
      end
      OP_IDLE:  repeat (arg) cyc(0, 0, 0, 0, 0);
      OP_PRESS: cyc(0, 1, 0, 0, 0);
      OP_TICKS: repeat (arg) begin
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
      end
      OP_ML:  cyc(0, 0, 1, 0, 0);
      OP_MR:  cyc(0, 0, 0, 1, 0);
      OP_MB:  cyc(0, 0, 1, 1, 0);
      default: cyc(1, 0, 0, 0, 0);
    endcase
  endtask

  task automatic add(input int op, input int arg, input int hold, input int run,
                     input int s1, input int s2, input int over, input int dir,
                     input int strobe, input int win);
    vec_t v;
    v = '{op, arg, hold, run, s1, s2, over, dir, strobe, win};
    tbl.push_back(v);
  endtask

  initial begin
    bit sb_lvl;
    //   op          arg hold run s1 s2 ovr dir stb win
    add(OP_RSTHOLD,  0,  1,   0,  0, 0, 0,  0,  0,  0);  // button held through reset
    add(OP_TICKS,   60,  1,   0,  0, 0, 0,  0,  0,  0);  // release alone: still IDLE
    add(OP_PRESS,    0,  1,   0,  0, 0, 0,  0,  0,  0);  // SERVE
    add(OP_TICKS,   59,  1,   0,  0, 0, 0,  0,  0,  0);
    add(OP_TICKS,    1,  0,   1,  0, 0, 0,  0,  0,  0);  // PLAY after exactly 60
    add(OP_PRESS,    0,  0,   1,  0, 0, 0,  0,  0,  0);  // press in PLAY ignored
    add(OP_MR,       0,  1,   0,  1, 0, 0,  0,  1,  0);
    add(OP_IDLE,     1,  1,   0,  1, 0, 0,  0,  0,  0);  // strobe one cycle only
    add(OP_TICKS,   30,  1,   0,  1, 0, 0,  0,  0,  0);
    add(OP_TICKS,   59,  1,   0,  1, 0, 0,  0,  0,  0);
    add(OP_TICKS,    1,  0,   1,  1, 0, 0,  0,  0,  0);  // PLAY after 30+60
    add(OP_MB,       0,  1,   0,  1, 0, 0,  0,  0,  0);  // both: no point, SERVE
    add(OP_TICKS,   60,  0,   1,  1, 0, 0,  0,  0,  0);
    add(OP_ML,       0,  1,   0,  1, 1, 0,  1,  1,  0);
    add(OP_MR,       0,  1,   0,  1, 1, 0,  1,  0,  0);  // miss in POINT ignored
    add(OP_TICKS,   90,  0,   1,  1, 1, 0,  1,  0,  0);
    add(OP_ML,       0,  1,   0,  1, 2, 0,  1,  1,  0);
    add(OP_TICKS,   90,  0,   1,  1, 2, 0,  1,  0,  0);
    add(OP_ML,       0,  1,   0,  1, 3, 0,  1,  1,  0);
    add(OP_TICKS,   29,  1,   0,  1, 3, 0,  1,  0,  0);
    add(OP_TICKS,    1,  1,   0,  1, 3, 1,  1,  0,  1);  // OVER, player 2 wins
    add(OP_ML,       0,  1,   0,  1, 3, 1,  1,  0,  1);  // ignored in OVER
    add(OP_PRESS,    0,  1,   0,  0, 0, 0,  0,  0,  0);  // new game, SERVE
    add(OP_TICKS,   60,  0,   1,  0, 0, 0,  0,  0,  0);
    add(OP_MR,       0,  1,   0,  1, 0, 0,  0,  1,  0);
    add(OP_TICKS,   90,  0,   1,  1, 0, 0,  0,  0,  0);
    add(OP_MR,       0,  1,   0,  2, 0, 0,  0,  1,  0);
    add(OP_TICKS,    5,  1,   0,  2, 0, 0,  0,  0,  0);  // mid POINT
    add(OP_RST,      0,  1,   0,  0, 0, 0,  0,  0,  0);  // reset during POINT
    add(OP_PRESS,    0,  1,   0,  0, 0, 0,  0,  0,  0);  // edge reg reset to 1: no serve
    add(OP_TICKS,   60,  1,   0,  0, 0, 0,  0,  0,  0);  // confirms still IDLE
    add(OP_PRESS,    0,  1,   0,  0, 0, 0,  0,  0,  0);  // SERVE
    add(OP_ML,       0,  1,   0,  0, 0, 0,  0,  0,  0);  // miss in SERVE ignored
    add(OP_TICKS,   60,  0,   1,  0, 0, 0,  0,  0,  0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply_op(tbl[i].op, tbl[i].arg);
      chk($sformatf("row%0d_hold", i),   ball_hold,    tbl[i].hold);
      chk($sformatf("row%0d_run", i),    ball_run,     tbl[i].run);
      chk($sformatf("row%0d_s1", i),     score1,       tbl[i].s1);
      chk($sformatf("row%0d_s2", i),     score2,       tbl[i].s2);
      chk($sformatf("row%0d_over", i),   game_over,    tbl[i].over);
      chk($sformatf("row%0d_dir", i),    serve_dir,    tbl[i].dir);
      chk($sformatf("row%0d_strobe", i), point_strobe, tbl[i].strobe);
      if (tbl[i].over == 1) chk($sformatf("row%0d_winner", i), winner, tbl[i].win);
    end

    // Randomised play against the reference model.
    sb_lvl = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 19) == 0) sb_lvl = !sb_lvl;
      cyc(($urandom_range(0, 1499) == 0),
          sb_lvl,
          ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
